hzu_scoreboard: RTL and testbench

- Parametrised successor of the per-thread RAW hazard unit for the multithreaded in-order core.
- Replaces the fixed 8-entry instruction history with a per-thread, per-register countdown scoreboard.
- Per-kind result latencies, selectable forwarding/no-forwarding mode, pipeline-freeze support, per-thread flush, optional memory serialisation.
- Sits between decode and issue; gates issue and produces the registered isvalid for the next stage.

---
 rtl/hzu_scoreboard_pkg.sv | 63 ++++++
 rtl/hzu_scoreboard_if.sv | 43 ++++
 rtl/hzu_thread_sb.sv | 39 +++
 rtl/hzu_scoreboard.sv | 143 ++++++++++++++
 tb/tb_hzu_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hzu_scoreboard_pkg.sv
// Shared types and decode helpers for the per-thread countdown hazard scoreboard.
// Decode uses has_src2/has_dst/instr_kind to drive the scoreboard's operand flags.
package hzu_scoreboard_pkg;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'd0,
        KIND_MUL   = 2'd1,
        KIND_LOAD  = 2'd2,
        KIND_STORE = 2'd3
    } instr_kind_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_MOV = 4'd5,
        OP_MUL = 4'd6,
        OP_LDW = 4'd7,
        OP_STW = 4'd8,
        OP_BEQ = 4'd9
    } opcode_t;

    // A one-thread core still needs a 1-bit thread field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // The store's data register travels on src2.
    function automatic logic has_src2(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_STW, OP_BEQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic has_dst(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_MUL, OP_LDW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic instr_kind_t instr_kind(input opcode_t op);
        case (op)
            OP_MUL:  return KIND_MUL;
            OP_LDW:  return KIND_LOAD;
            OP_STW:  return KIND_STORE;
            default: return KIND_ALU;
        endcase
    endfunction

endpackage

// File: rtl/hzu_scoreboard_if.sv
// Decode-to-issue handshake seen by the hazard scoreboard.
// master = decode side, slave = scoreboard.
interface hzu_scoreboard_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 32
);
    import hzu_scoreboard_pkg::*;

    localparam int TID_W = clog2_min1(NUM_THREADS);
    localparam int REG_W = clog2_min1(NUM_REGS);

    logic             in_valid;
    logic [TID_W-1:0] in_thread;
    logic [REG_W-1:0] in_src1;
    logic [REG_W-1:0] in_src2;
    logic             in_use_src2;
    logic [REG_W-1:0] in_dst;
    logic             in_has_dst;
    instr_kind_t      in_kind;
    logic             itlb_miss;
    logic             icache_miss;
    logic             stall;
    logic             flush;
    logic [TID_W-1:0] flush_thread;
    logic             issue;
    logic             hazard_raw;
    logic             hazard_mem;
    logic             isvalid;
    logic [TID_W-1:0] out_thread;

    modport master (
        output in_valid, in_thread, in_src1, in_src2, in_use_src2, in_dst, in_has_dst,
               in_kind, itlb_miss, icache_miss, stall, flush, flush_thread,
        input  issue, hazard_raw, hazard_mem, isvalid, out_thread
    );

    modport slave (
        input  in_valid, in_thread, in_src1, in_src2, in_use_src2, in_dst, in_has_dst,
               in_kind, itlb_miss, icache_miss, stall, flush, flush_thread,
        output issue, hazard_raw, hazard_mem, isvalid, out_thread
    );

endinterface

// File: rtl/hzu_thread_sb.sv
// One thread's bank of per-register countdown counters: two async read ports,
// one set port, global decrement and a whole-bank clear.
module hzu_thread_sb #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 3,
    parameter int REG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rd_addr1,
    input  logic [REG_W-1:0] rd_addr2,
    output logic [CNT_W-1:0] rd_cnt1,
    output logic [CNT_W-1:0] rd_cnt2,
    input  logic             dec_en,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic [CNT_W-1:0] set_val,
    input  logic             clear
);

    logic [CNT_W-1:0] cnt_reg [NUM_REGS];

    // Clear beats set beats decrement; with dec_en low the bank holds.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst || clear) begin
                cnt_reg[r] <= '0;
            end else if (set_en && set_addr == REG_W'(r)) begin
                cnt_reg[r] <= set_val;
            end else if (dec_en && cnt_reg[r] != '0) begin
                cnt_reg[r] <= cnt_reg[r] - CNT_W'(1);
            end
        end
    end

    assign rd_cnt1 = cnt_reg[rd_addr1];
    assign rd_cnt2 = cnt_reg[rd_addr2];

endmodule

// File: rtl/hzu_scoreboard.sv
// Per-thread RAW/memory hazard scoreboard between decode and issue: gates issue
// and registers isvalid/out_thread for the next stage.
module hzu_scoreboard
    import hzu_scoreboard_pkg::*;
#(
    parameter int NUM_THREADS   = 4,
    parameter int NUM_REGS      = 32,
    parameter int FORWARD       = 1,
    parameter int LAT_ALU       = 0,
    parameter int LAT_MUL       = 4,
    parameter int LAT_MEM       = 2,
    parameter int LAT_WB        = 4,
    parameter int SERIALIZE_MEM = 0,
    parameter int R0_ZERO       = 0
) (
    input logic clk,
    input logic rst,
    hzu_scoreboard_if.slave bus
);

    localparam int TID_W   = clog2_min1(NUM_THREADS);
    localparam int REG_W   = clog2_min1(NUM_REGS);
    localparam int MAX_LAT = max_of4(LAT_ALU, LAT_MUL, LAT_MEM, LAT_WB);
    localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (NUM_THREADS < 1) begin : g_chk_threads
        $error("hzu_scoreboard: NUM_THREADS must be at least 1");
    end
    if (NUM_REGS < 2) begin : g_chk_regs
        $error("hzu_scoreboard: NUM_REGS must be at least 2");
    end
    if (LAT_ALU > CNT_MAX || LAT_MUL > CNT_MAX || LAT_MEM > CNT_MAX || LAT_WB > CNT_MAX) begin : g_chk_lat
        $error("hzu_scoreboard: a latency does not fit the counter width");
    end

    logic [CNT_W-1:0]       rd1_cnt [NUM_THREADS];
    logic [CNT_W-1:0]       rd2_cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0] set_vec;
    logic [NUM_THREADS-1:0] clr_vec;
    logic [CNT_W-1:0]       src1_cnt;
    logic [CNT_W-1:0]       src2_cnt;
    logic [CNT_W-1:0]       set_lat;
    logic [CNT_W-1:0]       st_cnt_reg;
    logic                   isvalid_reg;
    logic [TID_W-1:0]       out_thread_reg;
    logic                   src1_busy, src2_busy, is_mem, flush_hit;
    logic                   hazard_raw, hazard_mem, issue, set_dst, store_issue;

    function automatic logic [CNT_W-1:0] lat_of(input instr_kind_t k);
        if (FORWARD == 0) return CNT_W'(LAT_WB);
        case (k)
            KIND_MUL:  return CNT_W'(LAT_MUL);
            KIND_LOAD: return CNT_W'(LAT_MEM);
            default:   return CNT_W'(LAT_ALU);
        endcase
    endfunction

    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
        assign clr_vec[gi] = bus.flush && (bus.flush_thread == TID_W'(gi));
        assign set_vec[gi] = set_dst && (bus.in_thread == TID_W'(gi));

        hzu_thread_sb #(
            .NUM_REGS (NUM_REGS),
            .CNT_W    (CNT_W),
            .REG_W    (REG_W)
        ) u_sb (
            .clk      (clk),
            .rst      (rst),
            .rd_addr1 (bus.in_src1),
            .rd_addr2 (bus.in_src2),
            .rd_cnt1  (rd1_cnt[gi]),
            .rd_cnt2  (rd2_cnt[gi]),
            .dec_en   (~bus.stall),
            .set_en   (set_vec[gi]),
            .set_addr (bus.in_dst),
            .set_val  (set_lat),
            .clear    (clr_vec[gi])
        );
    end

    // Only the issuing thread's bank is ever consulted.
    always_comb begin
        src1_cnt = '0;
        src2_cnt = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (bus.in_thread == TID_W'(t)) begin
                src1_cnt = rd1_cnt[t];
                src2_cnt = rd2_cnt[t];
            end
        end
    end

    assign src1_busy  = (src1_cnt != '0) && !((R0_ZERO != 0) && (bus.in_src1 == '0));
    assign src2_busy  = (src2_cnt != '0) && !((R0_ZERO != 0) && (bus.in_src2 == '0));
    assign hazard_raw = bus.in_valid && (src1_busy || (bus.in_use_src2 && src2_busy));

    assign is_mem     = (bus.in_kind == KIND_LOAD) || (bus.in_kind == KIND_STORE);
    assign hazard_mem = (SERIALIZE_MEM != 0) && bus.in_valid && is_mem && (st_cnt_reg != '0);

    assign flush_hit  = bus.flush && (bus.flush_thread == bus.in_thread);
    assign issue      = bus.in_valid && !bus.itlb_miss && !bus.icache_miss && !bus.stall &&
                        !hazard_raw && !hazard_mem && !flush_hit;

    // With forwarding a store produces nothing the bypass network tracks.
    assign set_lat = lat_of(bus.in_kind);
    assign set_dst = issue && bus.in_has_dst &&
                     !((FORWARD != 0) && (bus.in_kind == KIND_STORE)) &&
                     !((R0_ZERO != 0) && (bus.in_dst == '0));

    assign store_issue = issue && (SERIALIZE_MEM != 0) && (bus.in_kind == KIND_STORE);

    // Store window survives flush: the store may already be committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_cnt_reg <= '0;
        end else if (!bus.stall) begin
            if (store_issue) begin
                st_cnt_reg <= CNT_W'(LAT_MEM);
            end else if (st_cnt_reg != '0) begin
                st_cnt_reg <= st_cnt_reg - CNT_W'(1);
            end
        end
    end

    // A flushed thread cannot issue, so reloading from issue also drops its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            isvalid_reg    <= 1'b0;
            out_thread_reg <= '0;
        end else if (!bus.stall) begin
            isvalid_reg    <= issue;
            out_thread_reg <= bus.in_thread;
        end
    end

    assign bus.issue      = issue;
    assign bus.hazard_raw = hazard_raw;
    assign bus.hazard_mem = hazard_mem;
    assign bus.isvalid    = isvalid_reg;
    assign bus.out_thread = out_thread_reg;

endmodule

// File: tb/tb_hzu_scoreboard.sv
// Directed bench: three scoreboard variants (forwarding, writeback-only,
// serialised memory with r0 hardwired) driven with identical stimulus.
module tb_hzu_scoreboard;
    import hzu_scoreboard_pkg::*;

    localparam int F = 0;  // FORWARD=1
    localparam int W = 1;  // FORWARD=0, LAT_WB=4
    localparam int S = 2;  // SERIALIZE_MEM=1, R0_ZERO=1

    logic        clk = 1'b0;
    logic        rst;
    logic        v, u2, hd, itlb, icm, stl, fl;
    logic [1:0]  thr, flt;
    logic [4:0]  s1, s2, dst;
    instr_kind_t kind;

    logic [2:0]  issue_o, hraw_o, hmem_o, isvalid_o;
    logic [1:0]  othr_o [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hzu_scoreboard_if #(.NUM_THREADS(4), .NUM_REGS(32)) bus [3] ();

    for (genvar gi = 0; gi < 3; gi++) begin : g_bus
        assign bus[gi].in_valid     = v;
        assign bus[gi].in_thread    = thr;
        assign bus[gi].in_src1      = s1;
        assign bus[gi].in_src2      = s2;
        assign bus[gi].in_use_src2  = u2;
        assign bus[gi].in_dst       = dst;
        assign bus[gi].in_has_dst   = hd;
        assign bus[gi].in_kind      = kind;
        assign bus[gi].itlb_miss    = itlb;
        assign bus[gi].icache_miss  = icm;
        assign bus[gi].stall        = stl;
        assign bus[gi].flush        = fl;
        assign bus[gi].flush_thread = flt;
        assign issue_o[gi]          = bus[gi].issue;
        assign hraw_o[gi]           = bus[gi].hazard_raw;
        assign hmem_o[gi]           = bus[gi].hazard_mem;
        assign isvalid_o[gi]        = bus[gi].isvalid;
        assign othr_o[gi]           = bus[gi].out_thread;
    end

    hzu_scoreboard #(.FORWARD(1)) dut_fwd (.clk(clk), .rst(rst), .bus(bus[0]));
    hzu_scoreboard #(.FORWARD(0), .LAT_WB(4)) dut_wb (.clk(clk), .rst(rst), .bus(bus[1]));
    hzu_scoreboard #(.FORWARD(1), .SERIALIZE_MEM(1), .R0_ZERO(1)) dut_ser (.clk(clk), .rst(rst), .bus(bus[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v = 0; thr = 0; s1 = 0; s2 = 0; u2 = 0; dst = 0; hd = 0; kind = KIND_ALU;
        itlb = 0; icm = 0; stl = 0; fl = 0; flt = 0;
    endtask

    task automatic drive(input logic [1:0] t, input logic [4:0] a, input logic [4:0] b,
                         input logic ub, input logic [4:0] d, input logic hdst, input instr_kind_t k);
        v = 1; thr = t; s1 = a; s2 = b; u2 = ub; dst = d; hd = hdst; kind = k;
        $display("[%0t] tx thr=%0d src1=%0d src2=%0d use2=%0b dst=%0d has_dst=%0b kind=%s stall=%0b flush=%0b",
                 $time, t, a, b, ub, d, hdst, k.name(), stl, fl);
    endtask

    task automatic reset_all();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        #4;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (isvalid_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset_isvalid[%0d]: got %b want 0", i, isvalid_o[i]); end
            n_cmp++;
            if (othr_o[i] !== 2'd0) begin n_bad++; $display("FAIL reset_out_thread[%0d]: got %0d want 0", i, othr_o[i]); end
        end
        tick();
        rst = 0;
        drive(2'd2, 5'd5, 5'd6, 1'b1, 5'd1, 1'b0, KIND_ALU);
        #4;
        n_cmp++;
        if (hraw_o[F] !== 1'b0) begin n_bad++; $display("FAIL reset_hazard_raw: got %b want 0", hraw_o[F]); end
        n_cmp++;
        if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL reset_issue: got %b want 1", issue_o[F]); end
        tick();
        idle();
    endtask

    task automatic test_alu_back_to_back();
        reset_all();
        drive(2'd0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, KIND_ALU);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL alu_c0_issue: got %b want 1", issue_o[F]); end
        tick();
        drive(2'd0, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1, KIND_ALU);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL alu_c1_issue: got %b want 1", issue_o[F]); end
        n_cmp++;
        if (hraw_o[F] !== 1'b0) begin n_bad++; $display("FAIL alu_c1_hazard_raw: got %b want 0", hraw_o[F]); end
        n_cmp++;
        if (isvalid_o[F] !== 1'b1) begin n_bad++; $display("FAIL alu_c1_isvalid: got %b want 1", isvalid_o[F]); end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        logic [2:0] want;
        want = 3'b100;
        reset_all();
        drive(2'd0, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, KIND_LOAD);
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(2'd0, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, KIND_ALU);
            #4;
            n_cmp++;
            if (issue_o[F] !== want[c-1]) begin n_bad++; $display("FAIL load_use_c%0d_issue: got %b want %b", c, issue_o[F], want[c-1]); end
            n_cmp++;
            if (hraw_o[F] !== ~want[c-1]) begin n_bad++; $display("FAIL load_use_c%0d_hazard_raw: got %b want %b", c, hraw_o[F], ~want[c-1]); end
            tick();
        end
        // other thread is unaffected
        reset_all();
        drive(2'd0, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, KIND_LOAD);
        tick();
        drive(2'd1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, KIND_ALU);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL load_use_t1_issue: got %b want 1", issue_o[F]); end
        tick();
        // src2 not read
        reset_all();
        drive(2'd0, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, KIND_LOAD);
        tick();
        drive(2'd0, 5'd2, 5'd5, 1'b0, 5'd8, 1'b1, KIND_ALU);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL load_use_nosrc2_issue: got %b want 1", issue_o[F]); end
        tick();
        idle();
    endtask

    task automatic test_writeback_mode();
        reset_all();
        drive(2'd0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, KIND_ALU);
        tick();
        for (int c = 1; c <= 5; c++) begin
            drive(2'd0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, KIND_ALU);
            #4;
            n_cmp++;
            if (issue_o[W] !== (c == 5)) begin n_bad++; $display("FAIL wb_c%0d_issue: got %b want %b", c, issue_o[W], (c == 5)); end
            if (c == 1) begin
                n_cmp++;
                if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL wb_fwd_contrast_issue: got %b want 1", issue_o[F]); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_stall();
        reset_all();
        drive(2'd0, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, KIND_LOAD);
        tick();
        for (int c = 1; c <= 6; c++) begin
            stl = (c <= 3);
            drive(2'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, KIND_ALU);
            #4;
            n_cmp++;
            if (issue_o[F] !== (c == 6)) begin n_bad++; $display("FAIL stall_c%0d_issue: got %b want %b", c, issue_o[F], (c == 6)); end
            if (c <= 4) begin
                n_cmp++;
                if (isvalid_o[F] !== 1'b1) begin n_bad++; $display("FAIL stall_c%0d_isvalid: got %b want 1", c, isvalid_o[F]); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush_and_miss();
        reset_all();
        drive(2'd0, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, KIND_MUL);
        tick();
        fl = 1; flt = 2'd0;
        drive(2'd0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, KIND_ALU);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b0) begin n_bad++; $display("FAIL flush_c1_issue: got %b want 0", issue_o[F]); end
        tick();
        fl = 0;
        drive(2'd0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, KIND_ALU);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL flush_c2_issue: got %b want 1", issue_o[F]); end
        n_cmp++;
        if (hraw_o[F] !== 1'b0) begin n_bad++; $display("FAIL flush_c2_hazard_raw: got %b want 0", hraw_o[F]); end
        tick();
        reset_all();
        itlb = 1;
        drive(2'd0, 5'd1, 5'd2, 1'b1, 5'd9, 1'b1, KIND_MUL);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b0) begin n_bad++; $display("FAIL itlb_issue: got %b want 0", issue_o[F]); end
        n_cmp++;
        if (hraw_o[F] !== 1'b0) begin n_bad++; $display("FAIL itlb_hazard_raw: got %b want 0", hraw_o[F]); end
        tick();
        itlb = 0;
        drive(2'd0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, KIND_ALU);
        #4;
        n_cmp++;
        if (issue_o[F] !== 1'b1) begin n_bad++; $display("FAIL itlb_counter_untouched: got %b want 1", issue_o[F]); end
        n_cmp++;
        if (isvalid_o[F] !== 1'b0) begin n_bad++; $display("FAIL itlb_isvalid: got %b want 0", isvalid_o[F]); end
        tick();
        idle();
    endtask

    task automatic test_mem_serialize();
        reset_all();
        drive(2'd0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, KIND_STORE);
        #4;
        n_cmp++;
        if (issue_o[S] !== 1'b1) begin n_bad++; $display("FAIL ser_store_issue: got %b want 1", issue_o[S]); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(2'd1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, KIND_LOAD);
            #4;
            n_cmp++;
            if (hmem_o[S] !== (c != 3)) begin n_bad++; $display("FAIL ser_c%0d_hazard_mem: got %b want %b", c, hmem_o[S], (c != 3)); end
            n_cmp++;
            if (issue_o[S] !== (c == 3)) begin n_bad++; $display("FAIL ser_c%0d_issue: got %b want %b", c, issue_o[S], (c == 3)); end
            tick();
        end
        // reset in the middle of the store window
        reset_all();
        drive(2'd0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, KIND_STORE);
        tick();
        drive(2'd1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, KIND_LOAD);
        tick();
        rst = 1;
        tick();
        rst = 0;
        #4;
        n_cmp++;
        if (isvalid_o[S] !== 1'b0) begin n_bad++; $display("FAIL ser_rst_isvalid: got %b want 0", isvalid_o[S]); end
        n_cmp++;
        if (hmem_o[S] !== 1'b0) begin n_bad++; $display("FAIL ser_rst_hazard_mem: got %b want 0", hmem_o[S]); end
        n_cmp++;
        if (issue_o[S] !== 1'b1) begin n_bad++; $display("FAIL ser_rst_issue: got %b want 1", issue_o[S]); end
        tick();
        idle();
        #4;
        n_cmp++;
        if (isvalid_o[S] !== 1'b1) begin n_bad++; $display("FAIL ser_after_isvalid: got %b want 1", isvalid_o[S]); end
        n_cmp++;
        if (othr_o[S] !== 2'd1) begin n_bad++; $display("FAIL ser_after_out_thread: got %0d want 1", othr_o[S]); end
        tick();
    endtask

    task automatic test_r0_zero();
        reset_all();
        drive(2'd0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, KIND_LOAD);
        tick();
        drive(2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, KIND_ALU);
        #4;
        n_cmp++;
        if (hraw_o[S] !== 1'b0) begin n_bad++; $display("FAIL r0_zero_hazard_raw: got %b want 0", hraw_o[S]); end
        n_cmp++;
        if (hraw_o[F] !== 1'b1) begin n_bad++; $display("FAIL r0_normal_hazard_raw: got %b want 1", hraw_o[F]); end
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_writeback_mode();
        test_stall();
        test_flush_and_miss();
        test_mem_serialize();
        test_r0_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
